// File: rtl/mips_isa_pkg.sv
// Shared MIPS encoding constants and op-select enum, used by the loader
// and by the control / alu_control decoders.
package mips_isa_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_LW  = 4'd6,
    OP_SW  = 4'd7,
    OP_BEQ = 4'd8,
    OP_BNE = 4'd9
  } op_sel_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational symbolic-request to 32-bit MIPS word encoder.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  always_comb begin
    o_word  = '0;
    o_legal = is_legal_op(i_op);
    case (i_op)
      OP_ADD:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_ADD};
      OP_SUB:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_SUB};
      OP_AND:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_AND};
      OP_OR:   o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_OR};
      OP_XOR:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_XOR};
      OP_SLT:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b0, FUNC_SLT};
      OP_LW:   o_word = {OPC_LW,  i_rs, i_rt, i_imm};
      OP_SW:   o_word = {OPC_SW,  i_rs, i_rt, i_imm};
      OP_BEQ:  o_word = {OPC_BEQ, i_rs, i_rt, i_imm};
      OP_BNE:  o_word = {OPC_BNE, i_rs, i_rt, i_imm};
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/imem_prog_loader.sv
// Loads encoded instructions into instruction memory at consecutive word
// addresses over a valid/ready request stream.
//
// state  | meaning
// IDLE   | waiting for start
// ACCEPT | in_ready high, waiting for a request
// WRITE  | one-cycle imem write strobe
// DONE   | session finished, waiting for start
module imem_prog_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_len;
  logic              r_last;
  logic              r_err;
  logic              r_ovf;
  logic [31:0]       w_word;
  logic              w_legal;

  instr_encoder u_enc (
    .i_op   (in_op),
    .i_rs   (in_rs),
    .i_rt   (in_rt),
    .i_rd   (in_rd),
    .i_imm  (in_imm),
    .o_word (w_word),
    .o_legal(w_legal)
  );

  // Handshake/strobe outputs decode straight from state so an async reset
  // kills a write strobe without waiting for a clock edge.
  assign in_ready   = (r_state == S_ACCEPT);
  assign imem_we    = (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign prog_len   = r_len;
  assign err        = r_err;
  assign ovf        = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= ADDR_BASE;
      r_wdata <= '0;
      r_len   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr  <= ADDR_BASE;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            r_last <= in_last;
            if (w_legal) begin
              r_wdata <= w_word;
              r_state <= S_WRITE;
            end else begin
              r_err   <= 1'b1;
              r_state <= in_last ? S_DONE : S_ACCEPT;
            end
          end
        end
        S_WRITE: begin
          r_len <= r_len + (ADDR_W+1)'(1);
          // Address saturates at the top of memory rather than wrapping.
          if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_W'(1);
          if (r_last) begin
            r_state <= S_DONE;
          end else if (r_addr == ADDR_MAX) begin
            r_ovf   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ACCEPT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: a default-size instance plus an ADDR_W=2
// instance sharing the same request stream, checked against a word model.
module tb_imem_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        in_ready, imem_we, done, err, ovf;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  prog_len;

  logic        s_in_ready, s_imem_we, s_done, s_err, s_ovf;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_prog_len;

  int total = 0;
  int bad = 0;

  logic [39:0] obs_q[$];
  logic [33:0] sobs_q[$];
  logic        prev_we = 1'b0;
  logic        s_prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .prog_len(prog_len), .done(done), .err(err), .ovf(ovf)
  );

  imem_prog_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .prog_len(s_prog_len), .done(s_done), .err(s_err),
    .ovf(s_ovf)
  );

  // Write monitors: every strobe is logged, never back-to-back, never with in_ready.
  always @(negedge clk) begin
    if (imem_we) begin
      total++;
      if (prev_we || in_ready) begin
        bad++;
        $display("FAIL we_protocol: prev_we=%0b in_ready=%0b required 0/0", prev_we, in_ready);
      end
      obs_q.push_back({imem_addr, imem_wdata});
    end
    prev_we = imem_we;
    if (s_imem_we) begin
      total++;
      if (s_prev_we || s_in_ready) begin
        bad++;
        $display("FAIL small_we_protocol: prev_we=%0b in_ready=%0b required 0/0", s_prev_we, s_in_ready);
      end
      sobs_q.push_back({s_imem_addr, s_imem_wdata});
    end
    s_prev_we = s_imem_we;
  end

  function automatic logic [31:0] model_enc(input int op, input int rs, input int rt,
                                            input int rd, input int imm);
    longint w;
    int funcs[6] = '{32, 34, 36, 37, 38, 42};
    int opcs[4]  = '{35, 43, 4, 5};
    if (op < 6) w = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11) + funcs[op];
    else        w = longint'(opcs[op-6]) * (1 << 26) + longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + imm;
    return w[31:0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic last);
    bit ok;
    int k;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    ok = 0;
    k = 0;
    while (!ok && k < 50) begin
      if (sel ? s_in_ready : in_ready) ok = 1;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_accept: not accepted in 50 cycles, op=%0d", op);
    end
  endtask

  task automatic wait_done(input bit sel);
    int k = 0;
    while (!(sel ? s_done : done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!(sel ? s_done : done)) begin
      bad++;
      $display("FAIL wait_done: done never rose (sel=%0b)", sel);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, imem_we, done, err, ovf} !== 5'b0 || imem_addr !== 8'd0 ||
        imem_wdata !== 32'd0 || prog_len !== 9'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b we=%0b done=%0b err=%0b ovf=%0b addr=%0d wd=%h len=%0d required all 0",
               in_ready, imem_we, done, err, ovf, imem_addr, imem_wdata, prog_len);
    end
  endtask

  task automatic test_single_add();
    obs_q.delete();
    pulse_start();
    send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    wait_done(0);
    total++;
    if (obs_q.size() !== 1 || obs_q[0] !== {8'd0, 32'h00221820}) begin
      bad++;
      $display("FAIL single_add: writes=%0d first=%h required 1 write 00_00221820",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 40'h0);
    end
    total++;
    if (done !== 1'b1 || prog_len !== 9'd1 || err !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL single_add_status: done=%0b len=%0d err=%0b ovf=%0b required 1/1/0/0",
               done, prog_len, err, ovf);
    end
  endtask

  task automatic test_itypes();
    logic [31:0] exp_w[4];
    exp_w = '{32'h8C220004, 32'hAC220008, 32'h1022FFFF, 32'h1422FFFF};
    obs_q.delete();
    pulse_start();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL restart_done_drop: done=%0b required 0", done);
    end
    send(0, 4'd6, 5'd1, 5'd2, 5'd9, 16'h0004, 1'b0);
    send(0, 4'd7, 5'd1, 5'd2, 5'd9, 16'h0008, 1'b0);
    @(negedge clk);
    pulse_start();  // ignored mid-session
    send(0, 4'd8, 5'd1, 5'd2, 5'd9, 16'hFFFF, 1'b0);
    send(0, 4'd9, 5'd1, 5'd2, 5'd9, 16'hFFFF, 1'b1);
    wait_done(0);
    total++;
    if (obs_q.size() !== 4) begin
      bad++;
      $display("FAIL itypes_count: writes=%0d required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {8'(i), exp_w[i]}) begin
        bad++;
        $display("FAIL itypes_word%0d: got %h required %h", i, obs_q[i], {8'(i), exp_w[i]});
      end
    end
    total++;
    if (prog_len !== 9'd4 || err !== 1'b0) begin
      bad++;
      $display("FAIL itypes_len: len=%0d err=%0b required 4/0", prog_len, err);
    end
  endtask

  task automatic test_illegal();
    obs_q.delete();
    pulse_start();
    send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(0, 4'hF, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    total++;
    if (err !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL illegal_err: err=%0b done=%0b required 1/0", err, done);
    end
    send(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    wait_done(0);
    total++;
    if (obs_q.size() !== 2 || obs_q[0] !== {8'd0, 32'h00221820} ||
        obs_q[1] !== {8'd1, 32'h00221822}) begin
      bad++;
      $display("FAIL illegal_writes: n=%0d w0=%h w1=%h required 2 writes 00_00221820 01_00221822",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 40'h0,
               (obs_q.size() > 1) ? obs_q[1] : 40'h0);
    end
    total++;
    if (err !== 1'b1 || prog_len !== 9'd2) begin
      bad++;
      $display("FAIL illegal_status: err=%0b len=%0d required 1/2", err, prog_len);
    end
  endtask

  task automatic test_illegal_last();
    obs_q.delete();
    pulse_start();
    send(0, 4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    wait_done(0);
    total++;
    if (obs_q.size() !== 0 || prog_len !== 9'd0 || err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_last: writes=%0d len=%0d err=%0b required 0/0/1",
               obs_q.size(), prog_len, err);
    end
  endtask

  task automatic test_random();
    logic [39:0] exp_q[$];
    int op, rs, rt, rd, imm, n_legal;
    bit any_bad;
    obs_q.delete();
    n_legal = 0;
    any_bad = 0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      op  = $urandom_range(0, 12);
      rs  = $urandom_range(0, 31);
      rt  = $urandom_range(0, 31);
      rd  = $urandom_range(0, 31);
      imm = $urandom_range(0, 65535);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (op < 10) begin
        exp_q.push_back({8'(n_legal), model_enc(op, rs, rt, rd, imm)});
        n_legal++;
      end else begin
        any_bad = 1;
      end
      send(0, 4'(op), 5'(rs), 5'(rt), 5'(rd), 16'(imm), (i == 23));
    end
    wait_done(0);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL random_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (prog_len !== 9'(n_legal) || err !== any_bad || ovf !== 1'b0) begin
      bad++;
      $display("FAIL random_status: len=%0d err=%0b ovf=%0b required %0d/%0b/0",
               prog_len, err, ovf, n_legal, any_bad);
    end
  endtask

  task automatic test_overflow();
    bit seen_ready;
    sobs_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    wait_done(1);
    total++;
    if (s_ovf !== 1'b1 || s_done !== 1'b1 || s_prog_len !== 3'd4 || s_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ovf_status: ovf=%0b done=%0b len=%0d rdy=%0b required 1/1/4/0",
               s_ovf, s_done, s_prog_len, s_in_ready);
    end
    in_valid = 1'b1;
    seen_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_in_ready) seen_ready = 1;
    end
    in_valid = 1'b0;
    total++;
    if (seen_ready || sobs_q.size() !== 4) begin
      bad++;
      $display("FAIL ovf_fifth: ready_seen=%0b writes=%0d required 0/4", seen_ready, sobs_q.size());
    end
    for (int i = 0; i < 4 && i < sobs_q.size(); i++) begin
      total++;
      if (sobs_q[i] !== {2'(i), 32'h00221820}) begin
        bad++;
        $display("FAIL ovf_word%0d: got %h required %h", i, sobs_q[i], {2'(i), 32'h00221820});
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int k = 0;
    @(negedge clk);
    pulse_start();
    in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b1;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (imem_we !== 1'b1) begin
      bad++;
      $display("FAIL rst_write_entry: we=%0b required 1", imem_we);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({imem_we, in_ready, done, err, ovf} !== 5'b0 || imem_addr !== 8'd0 ||
        imem_wdata !== 32'd0 || prog_len !== 9'd0) begin
      bad++;
      $display("FAIL rst_mid_write: we=%0b rdy=%0b done=%0b addr=%0d wd=%h len=%0d required all 0",
               imem_we, in_ready, done, imem_addr, imem_wdata, prog_len);
    end
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    @(negedge clk);
    pulse_start();
    send(0, 4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 1'b1);
    wait_done(0);
    total++;
    if (obs_q.size() !== 1 || obs_q[0] !== {8'd0, 32'h00853020} || prog_len !== 9'd1) begin
      bad++;
      $display("FAIL rst_restart: n=%0d w=%h len=%0d required 1 write 00_00853020 len 1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 40'h0, prog_len);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_itypes();
    test_illegal();
    test_illegal_last();
    test_random();
    test_overflow();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Write-side counterpart of the opcode/func decoder: accepts symbolic instruction requests (op select, rs, rt, rd, imm) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word, using the same opcode/func values the control and alu_control decoders consume.
- Writes each word into instruction memory at consecutive word addresses. Used at bring-up and in benches to load programs before the core is released.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- in_valid  in  1  request valid
- in_ready  out  1  loader can accept a request
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_last  in  1  final instruction of the program
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- prog_len  out  ADDR_W+1  words written this session
- done  out  1  session finished; held until next start
- err  out  1  sticky: illegal op seen this session
- ovf  out  1  sticky: memory filled before in_last

Behaviour:
- Reset (async, any state): state=IDLE; in_ready, imem_we, done, err, ovf = 0; imem_addr=BASE_ADDR; imem_wdata=0; prog_len=0.
- Encoding, R-type (ops 0-5): {6'b000000, rs, rt, rd, 5'b0, func}. func: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLT 101010.
- Encoding, I-type: {opc, rs, rt, imm}. opc: LW 100011, SW 101011, BEQ 000100, BNE 000101. in_rd is ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. On start: addr=BASE_ADDR, prog_len=0, err=0, ovf=0, then go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready, register the encoded word and in_last.
  - Legal op: go to WRITE.
  - Illegal op: set err, drop the word (no write). Go to DONE if in_last, else stay in ACCEPT.
- WRITE: in_ready=0, imem_we=1 for exactly one cycle, carrying the registered addr/wdata. On that edge: addr+1, prog_len+1.
  - If last_q: go to DONE.
  - Else if the written addr was 2^ADDR_W-1: set ovf, go to DONE (no wrap).
  - Else: go to ACCEPT.
- DONE: done=1, in_ready=0. A start here restarts the session exactly as from IDLE, and done drops the next cycle.
- Latency and throughput: accept at edge N, imem_we high during cycle N+1. Peak rate is one instruction per 2 cycles.
- start in ACCEPT/WRITE: ignored. A write in progress always completes.
- in_valid with in_ready=0: no effect. The requester must hold its data until accepted.
- Reset mid-WRITE: the strobe drops immediately. The partial session is lost and no done is raised.

Decomposition:
- Package mips_isa_pkg: 6-bit opcode constants (R-type, LW, SW, BEQ, BNE), 6-bit func constants, 4-bit op-select enum, and an is_legal_op function. The control decoders share the same package.
- Sub-module instr_encoder: purely combinational (op, rs, rt, rd, imm) to (word, legal). The loader FSM registers its output.

Test Plan:
- start, then ADD rs=1 rt=2 rd=3 with in_last=1 -> one imem_we at addr 0 with wdata 0x00221820; done=1; prog_len=1; err=0.
- LW rs=1 rt=2 imm=4, then SW imm=8, then BEQ imm=0xFFFF, then BNE imm=0xFFFF(last) -> writes 0x8C220004, 0xAC220008, 0x1022FFFF, 0x1422FFFF at addrs 0-3; prog_len=4.
- op=4'hF mid-program -> no write for that request; err=1 stays set; following legal op is written at the next unused address.
- ADDR_W=2, five non-last ADDs -> four writes (addrs 0-3); ovf=1 and done=1 after the 4th; in_ready=0 so the 5th is never accepted.
- in_valid held high with random stalls -> each accepted request is written exactly once, imem_we is never back-to-back, and in_ready=0 throughout every WRITE cycle.
- rst asserted during WRITE -> imem_we falls without a clock edge; all outputs return to reset values; the next start restarts at BASE_ADDR.
